dmem_responder: RTL

Data-memory responder that serves the dual-issue pipeline's two memory lanes (lane 0 = older slot, lane 1 = younger slot) from a single-ported byte array.
- Accepts requests on a valid/ready handshake per lane.
- Serialises same-cycle requests in program order.
- Returns a one-cycle-latency response on each lane.
- Sits on the memory side of the EX/MEM boundary and replaces the combinational data memory as the target of the core's load/store requests.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 72 +++++++
 rtl/dmem_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: default widths,
// arbitration state encoding, request record and the parity helper.
// Optional build macro: DMEM_PARITY_EN (adds a stored parity bit per entry).
package dmem_pkg;

   localparam int unsigned AW_DEF = 8;
   localparam int unsigned DW_DEF = 8;
   localparam int unsigned PAR_W  = 64;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   // Request record at the default configuration widths.
   typedef struct packed {
      logic              write;
      logic [AW_DEF-1:0] addr;
      logic [DW_DEF-1:0] wdata;
   } req_t;

   // Even parity bit: callers zero-extend, which leaves the parity unchanged.
   function automatic logic even_parity(input logic [PAR_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous byte array with registered read and synchronous
// active-low clear. Read data and parity flag are zero on any cycle that
// was not a load, so the responder can route them without extra muxing.
// Optional build macro: DMEM_PARITY_EN (each entry carries an even-parity bit).
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          write,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          perr
);

   localparam int unsigned DEPTH = 2 ** AW;

`ifdef DMEM_PARITY_EN
   logic [DW:0] mem [DEPTH];

   // Clear, store with parity, or load with parity check.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[AW'(i)] <= '0;
         end
         rdata <= '0;
         perr  <= 1'b0;
      end else begin
         rdata <= '0;
         perr  <= 1'b0;
         if (en) begin
            if (write) begin
               mem[addr] <= {even_parity(PAR_W'(wdata)), wdata};
            end else begin
               rdata <= mem[addr][DW-1:0];
               perr  <= even_parity(PAR_W'(mem[addr][DW-1:0])) != mem[addr][DW];
            end
         end
      end
   end
`else
   logic [DW-1:0] mem [DEPTH];

   // Clear, store, or load.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[AW'(i)] <= '0;
         end
         rdata <= '0;
      end else begin
         rdata <= '0;
         if (en) begin
            if (write) begin
               mem[addr] <= wdata;
            end else begin
               rdata <= mem[addr];
            end
         end
      end
   end

   assign perr = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Two-lane data-memory responder. Same-cycle requests are serialised with
// lane 0 first; lane 1 waits one cycle in a pending buffer (state PEND)
// while both lanes are held off. Responses arrive one cycle after the
// access executes, and only one lane can respond in any given cycle.
// Optional build macro: DMEM_PARITY_EN (see dmem_array).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid0,
   input  logic          req_write0,
   input  logic [AW-1:0] req_addr0,
   input  logic [DW-1:0] req_wdata0,
   output logic          req_ready0,
   input  logic          req_valid1,
   input  logic          req_write1,
   input  logic [AW-1:0] req_addr1,
   input  logic [DW-1:0] req_wdata1,
   output logic          req_ready1,
   output logic          rsp_valid0,
   output logic [DW-1:0] rsp_rdata0,
   output logic          rsp_valid1,
   output logic [DW-1:0] rsp_rdata1,
   output logic          rsp_perr0,
   output logic          rsp_perr1
);

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } pend_t;

   state_t        state;
   pend_t         pend;
   logic          acc_en;
   logic          acc_write;
   logic [AW-1:0] acc_addr;
   logic [DW-1:0] acc_wdata;
   logic [DW-1:0] arr_rdata;
   logic          arr_perr;

   assign req_ready0 = (state == ST_IDLE);
   assign req_ready1 = (state == ST_IDLE);

   // Select which request drives the array this cycle.
   always_comb begin
      acc_en    = 1'b0;
      acc_write = 1'b0;
      acc_addr  = '0;
      acc_wdata = '0;
      if (state == ST_PEND) begin
         acc_en    = 1'b1;
         acc_write = pend.write;
         acc_addr  = pend.addr;
         acc_wdata = pend.wdata;
      end else if (req_valid0) begin
         acc_en    = 1'b1;
         acc_write = req_write0;
         acc_addr  = req_addr0;
         acc_wdata = req_wdata0;
      end else if (req_valid1) begin
         acc_en    = 1'b1;
         acc_write = req_write1;
         acc_addr  = req_addr1;
         acc_wdata = req_wdata1;
      end
   end

   // Arbitration FSM, pending buffer and response-valid pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         pend       <= '0;
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               rsp_valid0 <= req_valid0;
               rsp_valid1 <= req_valid1 & ~req_valid0;
               if (req_valid0 && req_valid1) begin
                  pend  <= '{write: req_write1, addr: req_addr1, wdata: req_wdata1};
                  state <= ST_PEND;
               end
            end
            ST_PEND: begin
               rsp_valid0 <= 1'b0;
               rsp_valid1 <= 1'b1;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The array output already reads zero after stores and idle cycles, and
   // only one lane is ever valid, so gating by valid routes it to its lane.
   always_comb begin
      rsp_rdata0 = rsp_valid0 ? arr_rdata : '0;
      rsp_rdata1 = rsp_valid1 ? arr_rdata : '0;
      rsp_perr0  = rsp_valid0 & arr_perr;
      rsp_perr1  = rsp_valid1 & arr_perr;
   end

   dmem_array #(
      .AW (AW),
      .DW (DW)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .en    (acc_en),
      .write (acc_write),
      .addr  (acc_addr),
      .wdata (acc_wdata),
      .rdata (arr_rdata),
      .perr  (arr_perr)
   );

endmodule
